// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared FSM encoding and register map for vectored_intr_ctrl
package intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_EN_MASK = 2'd0;
    localparam logic [1:0] ADDR_PEND    = 2'd1;
    localparam logic [1:0] ADDR_ISR     = 2'd2;
    localparam logic [1:0] ADDR_GIE     = 2'd3;

    // Upper half of the mapped-IO window shared with the keypad.
    localparam logic [15:0] MMIO_BASE = 16'hBF80;

endpackage

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - lowest-index-wins priority encoder with valid flag
module prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [4:0]   id,
    output logic         valid
);

    // Scan downward so the lowest set index is the last assignment.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = 5'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vectored_intr_ctrl.sv
// rtl/vectored_intr_ctrl.sv - prioritised vectored interrupt controller; NESTED_INTR_EN enables preemption
module vectored_intr_ctrl
    import intr_pkg::*;
#(
    parameter int                  NUM_SRC   = 8,
    parameter logic [NUM_SRC-1:0]  EDGE_MASK = '1,
    parameter logic [31:0]         BASE_VEC  = 32'h0000_0008,
    parameter int                  VEC_SHIFT = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               intr,
    input  logic               inta,
    input  logic               eoi,
    output logic [31:0]        int_vec,
    output logic [4:0]         int_id,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata
);

    function automatic logic [NUM_SRC-1:0] bit_of(input logic [4:0] idx);
        return {{(NUM_SRC-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [31:0] vec_of(input logic [4:0] idx);
        return BASE_VEC + ({27'd0, idx} << VEC_SHIFT);
    endfunction

    logic [NUM_SRC-1:0] sync1, sync2, sync3;
    logic [NUM_SRC-1:0] pend_edge, en_mask, isr;
    logic               gie;
    state_t             state;

    logic [NUM_SRC-1:0] pend, req, edge_set, ack_clr, w1c;
    logic [4:0]         req_id, isr_id;
    logic               req_valid, isr_valid, nest_ok, ack_fire;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Level sources bypass the pending register and track the synchronised input.
    assign edge_set = sync2 & ~sync3 & EDGE_MASK;
    assign pend     = (pend_edge & EDGE_MASK) | (sync2 & ~EDGE_MASK);
    assign req      = pend & en_mask & {NUM_SRC{gie}};

    prio_enc #(.N(NUM_SRC)) u_req_enc (.req(req), .id(req_id), .valid(req_valid));
    prio_enc #(.N(NUM_SRC)) u_isr_enc (.req(isr), .id(isr_id), .valid(isr_valid));

    assign nest_ok = req_valid && (!isr_valid || (req_id < isr_id));

    always_comb begin
        ack_fire = 1'b0;
        if (state == ST_REQ) begin
            ack_fire = inta && req_valid;
        end
`ifdef NESTED_INTR_EN
        else if (state == ST_SERVICE) begin
            ack_fire = inta && intr && nest_ok;
        end
`endif
    end

    assign ack_clr = ack_fire ? (bit_of(req_id) & EDGE_MASK) : '0;
    assign w1c     = (cfg_we && cfg_addr == ADDR_PEND) ? cfg_wdata[NUM_SRC-1:0] : '0;

    // A fresh edge in the same cycle as an ack or W1C keeps the bit pending.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pend_edge <= '0;
        end else begin
            pend_edge <= (pend_edge & ~(ack_clr | w1c)) | edge_set;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            en_mask <= '0;
            gie     <= 1'b0;
        end else if (cfg_we) begin
            if (cfg_addr == ADDR_EN_MASK) en_mask <= cfg_wdata[NUM_SRC-1:0];
            if (cfg_addr == ADDR_GIE)     gie     <= cfg_wdata[0];
        end
    end

`ifdef NESTED_INTR_EN
    logic [NUM_SRC-1:0] isr_rest;
    logic [4:0]         rest_id;
    logic               rest_valid;

    assign isr_rest = isr & ~bit_of(isr_id);
    prio_enc #(.N(NUM_SRC)) u_rest_enc (.req(isr_rest), .id(rest_id), .valid(rest_valid));
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            intr    <= 1'b0;
            isr     <= '0;
            int_id  <= '0;
            int_vec <= BASE_VEC;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state <= ST_REQ;
                        intr  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!req_valid) begin
                        state <= ST_IDLE;
                        intr  <= 1'b0;
                    end else if (ack_fire) begin
                        state   <= ST_SERVICE;
                        intr    <= 1'b0;
                        isr     <= isr | bit_of(req_id);
                        int_id  <= req_id;
                        int_vec <= vec_of(req_id);
                    end
                end
                ST_SERVICE: begin
`ifdef NESTED_INTR_EN
                    if (ack_fire) begin
                        intr    <= 1'b0;
                        isr     <= isr | bit_of(req_id);
                        int_id  <= req_id;
                        int_vec <= vec_of(req_id);
                    end else if (eoi && isr_valid) begin
                        intr <= 1'b0;
                        isr  <= isr_rest;
                        if (rest_valid) begin
                            int_id  <= rest_id;
                            int_vec <= vec_of(rest_id);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        intr <= nest_ok;
                    end
`else
                    intr <= 1'b0;
                    if (eoi) begin
                        if (isr_valid) isr <= isr & ~bit_of(isr_id);
                        state <= ST_IDLE;
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                    intr  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_EN_MASK: cfg_rdata[NUM_SRC-1:0] = en_mask;
            ADDR_PEND:    cfg_rdata[NUM_SRC-1:0] = pend;
            ADDR_ISR:     cfg_rdata[NUM_SRC-1:0] = isr;
            ADDR_GIE:     cfg_rdata[0]           = gie;
            default:      cfg_rdata              = '0;
        endcase
    end

endmodule
